// File: rtl/demux_slot_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot_buffer
//  Description : Registered SIZE-way demultiplexer with a one-entry holding
//                slot per output channel. A valid/ready write stream carries
//                a channel index, and each accepted word waits in its slot
//                until that channel's consumer takes it. The module also
//                tracks how many slots are occupied.
//  Options     : define DEMUX_SLOT_ERR_EN to build a sticky error flag for
//                out-of-range selects. Without it, oErr is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_slot_buffer #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [$clog2(SIZE)-1:0]    iSelect,
    input  logic [WIDTH-1:0]           iData,
    output logic [SIZE-1:0]            oValid,
    input  logic [SIZE-1:0]            iReady,
    output logic [SIZE*WIDTH-1:0]      oData,
    output logic [$clog2(SIZE+1)-1:0]  oCount,
    output logic                       oErr
);

    localparam int SEL_W = $clog2(SIZE);
    localparam int CNT_W = $clog2(SIZE+1);

    logic [SIZE-1:0]       full;
    logic [SIZE-1:0]       full_next;
    logic [SIZE-1:0]       sel_onehot;
    logic [SIZE-1:0]       wr_fire;
    logic [SIZE-1:0]       rd_fire;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [WIDTH-1:0]      data [SIZE];

    // Decode the select. An out-of-range index matches no slot, so it is
    // never backpressured and its word simply falls away.
    always_comb begin
        sel_onehot = '0;
        for (int s = 0; s < SIZE; s++) begin
            sel_onehot[s] = (iSelect == SEL_W'(s));
        end
    end

    // A slot blocks a write only when it is full and its consumer is not
    // draining it this cycle. The iReady-to-oReady path is combinational.
    assign oReady    = ~|(sel_onehot & full & ~iReady);
    assign wr_fire   = sel_onehot & {SIZE{iValid & oReady}};
    assign rd_fire   = full & iReady;
    assign full_next = (full & ~rd_fire) | wr_fire;

    // The occupancy of the next state is the number of full bits.
    always_comb begin
        count_next = '0;
        for (int s = 0; s < SIZE; s++) begin
            count_next = count_next + CNT_W'(full_next[s]);
        end
    end

    // Slot occupancy and count. Reset takes priority over any fire.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            full  <= '0;
            count <= '0;
        end else begin
            full  <= full_next;
            count <= count_next;
        end
    end

    generate
        for (genvar s = 0; s < SIZE; s++) begin : g_slot
            // Load a slot's data register when a write lands on that slot.
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    data[s] <= '0;
                end else if (wr_fire[s]) begin
                    data[s] <= iData;
                end
            end

            // An empty slot presents zero. Stale data is kept but hidden.
            assign oData[s*WIDTH +: WIDTH] = data[s] & {WIDTH{full[s]}};
        end
    endgenerate

    assign oValid = full;
    assign oCount = count;

`ifdef DEMUX_SLOT_ERR_EN
    localparam logic [SEL_W:0] SIZE_L = (SEL_W+1)'(SIZE);
    logic err;
    logic sel_out_of_range;

    assign sel_out_of_range = ({1'b0, iSelect} >= SIZE_L);

    // The error flag is sticky. Once an out-of-range write is accepted,
    // it stays set until reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            err <= 1'b0;
        end else if (iValid && oReady && sel_out_of_range) begin
            err <= 1'b1;
        end
    end

    assign oErr = err;
`else
    assign oErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_slot_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_slot_buffer
//  Description : Directed testbench for demux_slot_buffer with WIDTH=32 and
//                SIZE=6.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_slot_buffer;

    localparam int WIDTH = 32;
    localparam int SIZE  = 6;

    logic              iClk;
    logic              iRst;
    logic              iValid;
    logic              oReady;
    logic [2:0]        iSelect;
    logic [WIDTH-1:0]  iData;
    logic [SIZE-1:0]   oValid;
    logic [SIZE-1:0]   iReady;
    logic [SIZE*WIDTH-1:0] oData;
    logic [2:0]        oCount;
    logic              oErr;

    int checks;
    int errors;

`ifdef DEMUX_SLOT_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    demux_slot_buffer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iValid  (iValid),
        .oReady  (oReady),
        .iSelect (iSelect),
        .iData   (iData),
        .oValid  (oValid),
        .iReady  (iReady),
        .oData   (oData),
        .oCount  (oCount),
        .oErr    (oErr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iValid = 1'b1; iSelect = 3'd0; iData = 32'hFFFF_FFFF; iReady = '1;
        tick(); tick();
        iRst = 1'b0; iValid = 1'b0; iReady = '0;
        #1;
        checks++; if (oValid !== 6'b0) begin errors++; $display("FAIL reset_valid got %b exp %b", oValid, 6'b0); end
        checks++; if (oData !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", oData); end
        checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", oCount); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", oErr); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", oReady); end
    endtask

    task automatic test_basic_write();
        iValid = 1'b1; iSelect = 3'd3; iData = 32'hDEAD_BEEF; iReady = '0;
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", oReady); end
        tick();
        iValid = 1'b0;
        #1;
        checks++; if (oValid !== 6'b001000) begin errors++; $display("FAIL basic_valid got %b exp 001000", oValid); end
        checks++; if (oData !== {64'h0, 32'hDEAD_BEEF, 96'h0}) begin errors++; $display("FAIL basic_data got %h", oData); end
        checks++; if (oCount !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", oCount); end
    endtask

    task automatic test_backpressure();
        iValid = 1'b1; iSelect = 3'd3; iData = 32'h1234_5678; iReady = '0;
        #1;
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", oReady); end
        repeat (5) tick();
        checks++; if (oData[3*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_hold_data got %h exp deadbeef", oData[3*32 +: 32]); end
        checks++; if (oCount !== 3'd1) begin errors++; $display("FAIL bp_hold_count got %0d exp 1", oCount); end
        iReady = 6'b001000;
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL bp_ready_high got %b exp 1", oReady); end
        tick();
        iValid = 1'b0; iReady = '0;
        #1;
        checks++; if (oData[3*32 +: 32] !== 32'h1234_5678) begin errors++; $display("FAIL bp_new_data got %h exp 12345678", oData[3*32 +: 32]); end
        checks++; if (oValid !== 6'b001000) begin errors++; $display("FAIL bp_valid got %b exp 001000", oValid); end
        checks++; if (oCount !== 3'd1) begin errors++; $display("FAIL bp_count got %0d exp 1", oCount); end
    endtask

    task automatic test_fill_drain();
        // Empty slot 3 first, so the fill can run without stalling.
        iReady = 6'b001000;
        tick();
        iReady = '0;
        #1;
        checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL drain3_count got %0d exp 0", oCount); end
        for (int i = 0; i < 6; i++) begin
            iValid = 1'b1; iSelect = 3'(i); iData = 32'hA0 + 32'(i);
            tick();
        end
        iValid = 1'b0;
        #1;
        checks++; if (oCount !== 3'd6) begin errors++; $display("FAIL fill_count got %0d exp 6", oCount); end
        checks++; if (oValid !== 6'h3F) begin errors++; $display("FAIL fill_valid got %h exp 3f", oValid); end
        checks++; if (oData[0 +: 32] !== 32'hA0) begin errors++; $display("FAIL fill_data0 got %h exp a0", oData[0 +: 32]); end
        checks++; if (oData[5*32 +: 32] !== 32'hA5) begin errors++; $display("FAIL fill_data5 got %h exp a5", oData[5*32 +: 32]); end
        // With every slot full, no write can be accepted without a read.
        iValid = 1'b1; iSelect = 3'd2;
        #1;
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", oReady); end
        iValid = 1'b0;
        iReady = 6'h3F;
        tick();
        iReady = '0;
        #1;
        checks++; if (oValid !== 6'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", oValid); end
        checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", oCount); end
        checks++; if (oData !== '0) begin errors++; $display("FAIL drain_data got %h exp 0", oData); end
    endtask

    task automatic test_out_of_range();
        iValid = 1'b1; iSelect = 3'd7; iData = 32'h99; iReady = '0;
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL oor_ready got %b exp 1", oReady); end
        tick();
        iValid = 1'b0;
        #1;
        checks++; if (oValid !== 6'b0) begin errors++; $display("FAIL oor_valid got %b exp 0", oValid); end
        checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL oor_count got %0d exp 0", oCount); end
        checks++; if (oErr !== ERR_EXP) begin errors++; $display("FAIL oor_err got %b exp %b", oErr, ERR_EXP); end
        tick();
        checks++; if (oErr !== ERR_EXP) begin errors++; $display("FAIL oor_err_sticky got %b exp %b", oErr, ERR_EXP); end
    endtask

    task automatic test_mixed_edge();
        iValid = 1'b1; iSelect = 3'd1; iData = 32'h11; iReady = '0;
        tick();
        iSelect = 3'd2; iData = 32'h55; iReady = 6'b000010;
        tick();
        iValid = 1'b0; iReady = '0;
        #1;
        checks++; if (oValid !== 6'b000100) begin errors++; $display("FAIL mixed_valid got %b exp 000100", oValid); end
        checks++; if (oCount !== 3'd1) begin errors++; $display("FAIL mixed_count got %0d exp 1", oCount); end
        checks++; if (oData[2*32 +: 32] !== 32'h55) begin errors++; $display("FAIL mixed_data2 got %h exp 55", oData[2*32 +: 32]); end
        checks++; if (oData[1*32 +: 32] !== 32'h0) begin errors++; $display("FAIL mixed_data1 got %h exp 0", oData[1*32 +: 32]); end
    endtask

    task automatic test_back_to_back();
        // Slot 2 is full. Read it and rewrite it on the same edge.
        iValid = 1'b1; iSelect = 3'd2; iData = 32'h66; iReady = 6'b000100;
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", oReady); end
        tick();
        iValid = 1'b0; iReady = '0;
        #1;
        checks++; if (oValid !== 6'b000100) begin errors++; $display("FAIL b2b_valid got %b exp 000100", oValid); end
        checks++; if (oCount !== 3'd1) begin errors++; $display("FAIL b2b_count got %0d exp 1", oCount); end
        checks++; if (oData[2*32 +: 32] !== 32'h66) begin errors++; $display("FAIL b2b_data got %h exp 66", oData[2*32 +: 32]); end
    endtask

    task automatic test_reset_mid();
        // Reset must win over a write that arrives on the same edge.
        iRst = 1'b1; iValid = 1'b1; iSelect = 3'd0; iData = 32'h77; iReady = '0;
        #1;
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", oReady); end
        tick();
        iRst = 1'b0; iValid = 1'b0;
        #1;
        checks++; if (oValid !== 6'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", oValid); end
        checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", oCount); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", oErr); end
    endtask

    initial begin
        checks = 0; errors = 0;
        iRst = 1'b1; iValid = 1'b0; iSelect = '0; iData = '0; iReady = '0;
        test_reset();
        test_basic_write();
        test_backpressure();
        test_fill_drain();
        test_out_of_range();
        test_mixed_edge();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
